// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_ctrl transmit path among NUM_REQ requesters.
// Define UART_ARB_TAG_EN to precede each payload frame with a tag frame carrying the granted index.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 3,
    parameter int DATA_BITS     = 7,
    parameter int GAP_CYCLES    = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]     active_id,
    output logic                           arb_busy,
    output logic                           timeout_err
);

    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE,
        GAP
`ifdef UART_ARB_TAG_EN
        ,
        TAG_BUSY,
        TAG_DONE
`endif
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_sel;
    logic                 grant_vld;
    logic [DATA_BITS-1:0] data_arr [NUM_REQ];

`ifdef UART_ARB_TAG_EN
    logic [DATA_BITS-1:0] hold_data;
    logic                 pay_pending;
`endif

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign data_arr[g] = req_data[g*DATA_BITS +: DATA_BITS];
    end

    // Search upward from rr_ptr; idx carries one extra bit so the wrap subtraction cannot overflow.
    always_comb begin
        logic [ID_W:0] idx;
        idx       = '0;
        grant_sel = '0;
        grant_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!grant_vld && req[idx[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_sel = idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            active_id   <= '0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
`ifdef UART_ARB_TAG_EN
            hold_data   <= '0;
            pay_pending <= 1'b0;
`endif
        end else begin
            ack         <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Holding off while tx_busy is still high keeps a late-finishing frame from overlapping.
                    if (grant_vld && !tx_busy) begin
                        ack       <= NUM_REQ'(1) << grant_sel;
                        tx_start  <= 1'b1;
                        active_id <= grant_sel;
                        rr_ptr    <= (grant_sel == ID_W'(NUM_REQ - 1)) ? '0 : grant_sel + 1'b1;
                        arb_busy  <= 1'b1;
                        cnt       <= '0;
`ifdef UART_ARB_TAG_EN
                        tx_data   <= DATA_BITS'(grant_sel);
                        hold_data <= data_arr[grant_sel];
                        state     <= TAG_BUSY;
`else
                        tx_data   <= data_arr[grant_sel];
                        state     <= WAIT_BUSY;
`endif
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        arb_busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            arb_busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
`ifdef UART_ARB_TAG_EN
                        if (pay_pending) begin
                            tx_data     <= hold_data;
                            tx_start    <= 1'b1;
                            pay_pending <= 1'b0;
                            cnt         <= '0;
                            state       <= WAIT_BUSY;
                        end else begin
                            arb_busy <= 1'b0;
                            state    <= IDLE;
                        end
`else
                        arb_busy <= 1'b0;
                        state    <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_ARB_TAG_EN
                TAG_BUSY: begin
                    if (tx_busy) begin
                        state <= TAG_DONE;
                    end else if (cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        arb_busy    <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TAG_DONE: begin
                    if (!tx_busy) begin
                        cnt <= '0;
                        if (GAP_CYCLES == 0) begin
                            tx_data  <= hold_data;
                            tx_start <= 1'b1;
                            state    <= WAIT_BUSY;
                        end else begin
                            pay_pending <= 1'b1;
                            state       <= GAP;
                        end
                    end
                end
`endif
                default: begin
                    arb_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
